// File: rtl/cpu_int_seq.sv
// cpu_int_seq: RESET/NMI/IRQ/BRK entry sequencer that borrows the bus for the stack pushes and vector fetch
module cpu_int_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] STACK_PAGE = 8'h01,
  parameter logic [ADDR_W-1:0] VEC_BASE = 16'hFFFA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              sync,
  input  logic              brk,
  input  logic              irq,
  input  logic              nmi,
  input  logic              i_flag,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] p_in,
  input  logic [DATA_W-1:0] sp_in,
  input  logic [DATA_W-1:0] d_in,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] d_out,
  output logic              write,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_load,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_load,
  output logic              set_i
);
  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6} state_t;
  typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;
  state_t state, state_nx;
  kind_t kind;
  logic brk_b;
  logic [ADDR_W-1:0] ret, vec_lo;
  logic [DATA_W-1:0] sp, p, vlo, p_push;
  logic nmi_prev, nmi_pend, nmi_edge, irq_pend, start, push, hijack;
  // Request decode: boundary start, stack-push window and NMI hijack of an IRQ/BRK entry
  always_comb begin
    nmi_edge = nmi & ~nmi_prev;
    irq_pend = irq & ~i_flag;
    start = state == IDLE && ready && sync && (nmi_pend || irq_pend || brk);
    push = state inside {S2, S3, S4};
    hijack = ready && state inside {S1, S2, S3, S4} && (kind == K_IRQ || kind == K_BRK) && (nmi_pend || nmi_edge);
    vec_lo = kind == K_NMI ? VEC_BASE : kind == K_RESET ? VEC_BASE + ADDR_W'(2) : VEC_BASE + ADDR_W'(4);
    p_push = p;
    p_push[5] = 1'b1;
    p_push[4] = brk_b;
    state_nx = state == IDLE ? (start ? S1 : IDLE) : state == S6 ? IDLE : state_t'(state + 3'd1);
  end
  // NMI edge detector runs even while ready is low; a new edge wins over the S5 clear
  always_ff @(posedge clk) begin
    nmi_prev <= nmi;
    nmi_pend <= reset ? 1'b0 : nmi_edge | (nmi_pend & ~(state == S5 && kind == K_NMI));
  end
  // Sequence state register; reset always restarts a RESET entry at S1
  always_ff @(posedge clk) begin
    if (reset) state <= S1;
    else if (ready) state <= state_nx;
  end
  // Latched context: kind, return address, working SP, status and vector low byte
  always_ff @(posedge clk) begin
    if (reset) begin
      kind <= K_RESET;
      brk_b <= 1'b0;
      ret <= pc_in;
      sp <= sp_in;
      p <= p_in;
      vlo <= '0;
    end else if (ready) begin
      if (start) begin
        kind <= nmi_pend ? K_NMI : irq_pend ? K_IRQ : K_BRK;
        brk_b <= !nmi_pend && !irq_pend;
        ret <= (nmi_pend || irq_pend) ? pc_in : pc_in + ADDR_W'(1);
        sp <= sp_in;
        p <= p_in;
      end
      if (hijack) kind <= K_NMI;
      if (push) sp <= sp - DATA_W'(1);
      if (state == S5) vlo <= d_in;
    end
  end
  // Bus and core-handoff outputs; reset kills strobes in the same cycle it is raised
  always_comb begin
    busy = reset || state != IDLE;
    addr = state == S1 ? ret : push ? {STACK_PAGE, sp} : state == S5 ? vec_lo : state == S6 ? vec_lo + ADDR_W'(1) : pc_in;
    d_out = (reset || !push) ? '0 : state == S2 ? ret[ADDR_W-1:DATA_W] : state == S3 ? ret[DATA_W-1:0] : p_push;
    write = !reset && push && kind != K_RESET;
    pc_load = !reset && state == S6;
    sp_load = pc_load;
    set_i = pc_load;
    pc_out = {d_in, vlo};
    sp_out = sp;
  end
endmodule

// File: doc/cpu_int_seq.md
Name: cpu_int_seq

Overview:
- Interrupt and reset entry sequencer for the 6502-class core.
- Takes over the bus at an instruction boundary to run the 7-cycle RESET/NMI/IRQ/BRK entry: dummy read, push PCH/PCL/P to the stack page, fetch the vector, then hand the new PC and SP back to the core.
- Parametrised in address/data width, stack page and vector base. Adds NMI edge detection, IRQ masking, priority resolution and NMI hijack, none of which the current core has.

Parameters:
- ADDR_W, 16, address bus width (must be 2*DATA_W).
- DATA_W, 8, data bus / register width.
- STACK_PAGE, 8'h01, high byte of stack addresses.
- VEC_BASE, 16'hFFFA, NMI vector low byte address. RESET = VEC_BASE+2, IRQ/BRK = VEC_BASE+4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ready  in  1  1 = advance; 0 = freeze all state (outputs held)
- sync  in  1  core is at an opcode fetch (instruction boundary)
- brk  in  1  core decoded BRK this cycle (sampled with sync)
- irq  in  1  level interrupt request, active-high
- nmi  in  1  non-maskable request, rising-edge sensitive
- i_flag  in  1  P.I from core
- pc_in  in  ADDR_W  core PC (return address)
- p_in  in  DATA_W  core status register
- sp_in  in  DATA_W  core stack pointer
- d_in  in  DATA_W  read data bus
- busy  out  1  sequencer owns bus; core must hold
- addr  out  ADDR_W  bus address while busy
- d_out  out  DATA_W  write data
- write  out  1  bus write strobe
- pc_out  out  ADDR_W  new PC (vector)
- pc_load  out  1  one-cycle pulse: core loads pc_out
- sp_out  out  DATA_W  new SP
- sp_load  out  1  one-cycle pulse, coincident with pc_load
- set_i  out  1  one-cycle pulse with pc_load: core sets P.I

Behaviour:
- Reset: busy=1, kind=RESET, state=S1. write=0, pc_load=0, sp_load=0, set_i=0, d_out=0. NMI edge latch cleared; nmi_prev<=nmi.
- Pending logic:
  - nmi_pend sets on nmi rising edge (nmi & ~nmi_prev) and clears when an NMI sequence reaches S5.
  - irq_pend = irq & ~i_flag, combinational and not latched.
- Start: in IDLE with ready & sync, priority is nmi_pend > irq_pend > brk. If any is active: busy=1, latch kind, ret=pc_in (brk: pc_in+1 wrapped), sp=sp_in, p=p_in, go to S1. Otherwise stay IDLE, busy=0.
- States, one cycle each when ready=1:
  - S1: addr=ret, read (dummy).
  - S2: addr={STACK_PAGE,sp}, d_out=ret[hi], write=1 (except RESET), sp<=sp-1.
  - S3: same as S2 with ret[lo].
  - S4: same as S2 with d_out = p with bit5=1 and bit4 = (kind==BRK).
  - S5: addr=vector low address, latch d_in into vlo.
  - S6: addr=vector low+1, pc_out={d_in,vlo}, pc_load=sp_load=set_i=1, sp_out=sp, go to IDLE. busy drops the following cycle.
- RESET performs the S2–S4 decrements with write=0, so SP ends at sp_in-3.
- sp arithmetic is mod 2^DATA_W (00 -> FF wrap). Stack addresses never leave STACK_PAGE.
- NMI hijack: an nmi edge detected in IRQ/BRK S1–S4 switches kind to NMI for vector selection; the pushed B bit keeps the original kind. Edges at S5 or later remain pending for the next boundary.
- ready=0: state, latches, outputs held. The NMI edge detector keeps sampling.
- reset mid-sequence: abort immediately, restart RESET S1 with no writes.
- Outside S2–S4, write=0. When busy=0, addr=pc_in and d_out=0.

Test Plan:
- Reset, sp_in=FD, mem[FFFC]=00, mem[FFFD]=C0 -> no write strobes; S6 pc_out=C000, sp_out=FA, set_i=1, pc_load 7th cycle after reset deassert.
- IRQ, i_flag=0, pc_in=1234, sp_in=FF, p_in=A1 at sync -> writes 12@01FF, 34@01FE, A1@01FD (B=0, bit5 already 1); vector read FFFE/FFFF; sp_out=FC.
- irq=1, i_flag=1, sync pulses -> busy stays 0. BRK at pc_in=2000 -> pushes 20,01, P with bit4=1, vector FFFE.
- nmi rising during IRQ S3 -> pushed P B=0, vector read from FFFA/FFFB, nmi_pend cleared. nmi held high afterwards -> no second sequence.
- sp_in=01 with NMI -> writes at 0101, 0100, 01FF; sp_out=FE.
- ready=0 for 3 cycles during S4 -> write, addr, d_out held; total latency +3. reset asserted in S3 -> write drops same cycle; RESET sequence restarts.
